// File: rtl/codec_cfg_pkg.sv
// Shared types and the codec register table for the configuration sequencer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_e;

    // One codec write: 7-bit register address and 9-bit value.
    typedef struct packed {
        logic [6:0] reg_addr;
        logic [8:0] reg_val;
    } cfg_entry_t;

    localparam int TABLE_LEN = 11;

    // Reset first, activate last; everything in between is the audio setup.
    localparam cfg_entry_t CFG_TABLE [TABLE_LEN] = '{
        '{7'd15, 9'h000},   // reset
        '{7'd0,  9'h017},   // left line in
        '{7'd1,  9'h017},   // right line in
        '{7'd2,  9'h079},   // left headphone
        '{7'd3,  9'h079},   // right headphone
        '{7'd4,  9'h012},   // analogue path
        '{7'd5,  9'h000},   // digital path
        '{7'd6,  9'h000},   // power down control
        '{7'd7,  9'h002},   // I2S, 16-bit, slave
        '{7'd8,  9'h000},   // sample rate
        '{7'd9,  9'h001}    // active
    };

    // Word presented to the I2C master: device byte then the register entry.
    function automatic logic [23:0] pack_i2c(input logic [7:0] dev, input cfg_entry_t e);
        return {dev, e};
    endfunction

endpackage

// File: rtl/codec_cfg_seq_if.sv
// I2C master handshake between the configuration sequencer and the I2C engine.
// Latency: wires only.
// Backpressure: the engine paces the sequencer through i2c_end; go is never held.
interface codec_cfg_seq_if;
    logic [23:0] i2c_data;
    logic        i2c_go;
    logic        i2c_end;
    logic        i2c_ack_err;

    // Sequencer side: launches transactions and waits for completion.
    modport master (
        output i2c_data,
        output i2c_go,
        input  i2c_end,
        input  i2c_ack_err
    );

    // I2C engine side: consumes the word and reports completion/NACK.
    modport slave (
        input  i2c_data,
        input  i2c_go,
        output i2c_end,
        output i2c_ack_err
    );
endinterface

// File: rtl/codec_cfg_seq_rom.sv
// Table lookup: entry index to {reg_addr, reg_val}.
// Latency: combinational.
// Backpressure: none.
module cfg_rom
    import codec_cfg_pkg::*;
(
    input  logic [3:0]  idx,
    output cfg_entry_t  entry
);

    // Indices past the end of the table read as a null entry.
    always_comb begin
        entry = '0;
        if (32'(idx) < TABLE_LEN) begin
            entry = CFG_TABLE[idx];
        end
    end

endmodule

// File: rtl/codec_cfg_seq.sv
// Walks the codec register table, one I2C write per entry, with retry on NACK/timeout.
// Latency: LOAD+ISSUE (2 cycles) to go, then master time, then GAP_CYCLES between writes.
// Backpressure: waits for i2c_end up to TIMEOUT_CYCLES; start is ignored while busy.
module codec_cfg_seq
    import codec_cfg_pkg::*;
#(
    parameter int          NUM_REGS       = 11,
    parameter logic [7:0]  DEV_ADDR       = 8'h34,
    parameter int          GAP_CYCLES     = 1000,
    parameter int          TIMEOUT_CYCLES = 200000,
    parameter int          MAX_RETRY      = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    codec_cfg_seq_if.master         i2c,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [3:0]              reg_index
);

    // Counters only ever count up to their terminal value, never wrap.
    localparam int GAP_W = (GAP_CYCLES > 1)     ? $clog2(GAP_CYCLES)     : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RTY_W = (MAX_RETRY > 0)      ? $clog2(MAX_RETRY + 1)  : 1;

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [3:0]       IDX_LAST = 4'(NUM_REGS - 1);

    state_e             state_q,   state_d;
    logic [3:0]         idx_q,     idx_d;
    logic [RTY_W-1:0]   retry_q,   retry_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [23:0]        data_q,    data_d;
    logic               ok_q,      ok_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               error_q,   error_d;

    cfg_entry_t         rom_entry;

    cfg_rom u_rom (
        .idx   (idx_q),
        .entry (rom_entry)
    );

    // Next-state and counter logic; a failed attempt either retries the same entry or gives up.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        gap_cnt_d = gap_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        data_d    = data_q;
        ok_d      = ok_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    retry_d = '0;
                    ok_d    = 1'b0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                data_d  = pack_i2c(DEV_ADDR, rom_entry);
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion in the timeout cycle still counts as a completion.
                if (i2c.i2c_end && !i2c.i2c_ack_err) begin
                    retry_d = '0;
                    ok_d    = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end
                end else if (i2c.i2c_end || (tmo_cnt_q == TMO_LAST)) begin
                    if (retry_q < RTY_MAX) begin
                        retry_d   = retry_q + 1'b1;
                        ok_d      = 1'b0;
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_LOAD;
                    if (ok_q) begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset silently abandons any transaction.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            retry_q   <= '0;
            gap_cnt_q <= '0;
            tmo_cnt_q <= '0;
            data_q    <= '0;
            ok_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            gap_cnt_q <= gap_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            data_q    <= data_d;
            ok_q      <= ok_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign i2c.i2c_go   = (state_q == ST_ISSUE);
    assign i2c.i2c_data = data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign reg_index    = idx_q;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Self-checking bench: per-attempt responder decisions feed an attempt-level reference model.
// Latency: n/a.
// Backpressure: the responder answers each go after a chosen delay, with NACK, or never.
module tb_codec_cfg_seq;

    localparam int N    = 11;
    localparam int GAP  = 20;
    localparam int TMO  = 100;
    localparam int MAXR = 3;

    localparam int REG_A [11] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    localparam int REG_V [11] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012,
                                  'h000, 'h000, 'h002, 'h000, 'h001};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_req = 1'b0;
    logic       spur = 1'b0;
    logic       spur_en = 1'b0;
    logic       start;
    logic       busy, done, error;
    logic [3:0] reg_index;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int          dec_lat[$];
    bit          dec_nack[$];
    int          rsp_lat[$];
    bit          rsp_nack[$];
    int          go_cyc[$];
    logic [23:0] go_dat[$];
    logic        prev_go = 1'b0;

    assign start = start_req | spur;

    codec_cfg_seq_if bus ();

    codec_cfg_seq #(
        .NUM_REGS       (N),
        .DEV_ADDR       (8'h34),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRY      (MAXR)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .i2c       (bus.master),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .reg_index (reg_index)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] ref_word(input int i);
        logic [6:0] a;
        logic [8:0] v;
        a = 7'(REG_A[i]);
        v = 9'(REG_V[i]);
        return {8'h34, a, v};
    endfunction

    // Responder: one decision per go (delay, NACK); delay 0 means never answer.
    initial begin
        bus.i2c_end     = 1'b0;
        bus.i2c_ack_err = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.i2c_go) begin
                int          lat;
                bit          nk;
                logic [23:0] d;
                lat = 50;
                nk  = 1'b0;
                if (rsp_lat.size() > 0) begin
                    lat = rsp_lat.pop_front();
                    nk  = rsp_nack.pop_front();
                end
                d = bus.i2c_data;
                if (lat > 0) begin
                    repeat (lat) @(negedge clk);
                    if (lat <= TMO) chk("data_hold", bus.i2c_data, d);
                    bus.i2c_end     = 1'b1;
                    bus.i2c_ack_err = nk;
                    @(negedge clk);
                    bus.i2c_end     = 1'b0;
                    bus.i2c_ack_err = 1'b0;
                end
            end
        end
    end

    // Go monitor: logs every launch and checks it lasts a single cycle.
    initial forever begin
        @(negedge clk);
        if (prev_go) chk("go_pulse", bus.i2c_go, 1'b0);
        if (bus.i2c_go) begin
            go_cyc.push_back(cyc);
            go_dat.push_back(bus.i2c_data);
        end
        prev_go = bus.i2c_go;
    end

    // Occasional start pulses while busy; these must change nothing.
    initial forever begin
        @(negedge clk);
        spur = spur_en && busy && ($urandom_range(0, 39) == 0);
    end

    task automatic pulse_start();
        @(negedge clk) start_req = 1'b1;
        @(negedge clk) start_req = 1'b0;
    endtask

    // Run the table once with the decisions in dec_*, then compare against the model.
    task automatic run_case(input string tag);
        logic [23:0] e_dat[$];
        int          e_dly[$];
        int          idx, rty, k, n;
        bit          e_done, e_err, fin;
        idx = 0; rty = 0; k = 0; e_done = 0; e_err = 0;
        while (!e_done && !e_err) begin
            int lat;
            bit nk, answered, ok;
            lat = (k < dec_lat.size())  ? dec_lat[k]  : 50;
            nk  = (k < dec_nack.size()) ? dec_nack[k] : 1'b0;
            answered = (lat > 0) && (lat <= TMO);
            ok = answered && !nk;
            e_dat.push_back(ref_word(idx));
            // go -> WAIT(lat or TMO) -> GAP -> LOAD -> ISSUE
            e_dly.push_back((answered ? lat : TMO) + GAP + 2);
            if (ok) begin
                if (idx == N - 1) e_done = 1;
                else begin idx++; rty = 0; end
            end else if (rty < MAXR) rty++;
            else e_err = 1;
            k++;
        end

        rsp_lat  = dec_lat;
        rsp_nack = dec_nack;
        go_cyc.delete();
        go_dat.delete();
        pulse_start();
        @(negedge clk);
        chk({tag, "/busy_on"}, busy, 1'b1);
        chk({tag, "/done_clr"}, done, 1'b0);
        chk({tag, "/err_clr"}, error, 1'b0);

        fin = 0;
        for (int c = 0; c < 20000 && !fin; c++) begin
            @(negedge clk);
            fin = done || error;
        end
        chk({tag, "/finish"}, fin, 1'b1);
        repeat (200) @(negedge clk);

        chk({tag, "/go_count"}, go_dat.size(), e_dat.size());
        n = (go_dat.size() < e_dat.size()) ? go_dat.size() : e_dat.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s/data%0d", tag, i), go_dat[i], e_dat[i]);
            if (i > 0) chk($sformatf("%s/spacing%0d", tag, i), go_cyc[i] - go_cyc[i-1], e_dly[i-1]);
        end
        chk({tag, "/done"}, done, e_done);
        chk({tag, "/error"}, error, e_err);
        chk({tag, "/busy_off"}, busy, 1'b0);
        chk({tag, "/reg_index"}, reg_index, idx);
    endtask

    task automatic set_decisions(input int n_ok, input int lat, input bit nk, input int n_bad);
        dec_lat.delete();
        dec_nack.delete();
        for (int i = 0; i < n_ok; i++) begin dec_lat.push_back(50); dec_nack.push_back(1'b0); end
        for (int i = 0; i < n_bad; i++) begin dec_lat.push_back(lat); dec_nack.push_back(nk); end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "/go"}, bus.i2c_go, 1'b0);
        chk({tag, "/data"}, bus.i2c_data, 24'h0);
        chk({tag, "/busy"}, busy, 1'b0);
        chk({tag, "/done"}, done, 1'b0);
        chk({tag, "/error"}, error, 1'b0);
        chk({tag, "/reg_index"}, reg_index, 4'd0);
    endtask

    initial begin
        int n;
        bit hit;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean run across the whole table.
        set_decisions(0, 50, 1'b0, 0);
        run_case("clean");
        chk("clean/first_word", (go_dat.size() > 0) ? go_dat[0] : 24'h0, 24'h341E00);
        chk("clean/last_word", (go_dat.size() > 0) ? go_dat[go_dat.size()-1] : 24'h0, 24'h341201);

        // Single NACK on entry 3, then success.
        set_decisions(3, 50, 1'b1, 1);
        run_case("nack_once");
        chk("nack_once/reissue_same", (go_dat.size() > 4) ? go_dat[4] : 24'h0,
            (go_dat.size() > 3) ? go_dat[3] : 24'hFFFFFF);

        // Entry 5 never acknowledged: four attempts then give up.
        set_decisions(5, 50, 1'b1, 4);
        run_case("nack_stuck");

        // Entry 0 never answered: four timeouts.
        set_decisions(0, 0, 1'b0, 4);
        run_case("timeout");

        // Reset while waiting on entry 6.
        set_decisions(6, 0, 1'b0, 1);
        rsp_lat  = dec_lat;
        rsp_nack = dec_nack;
        go_cyc.delete();
        go_dat.delete();
        pulse_start();
        hit = 0;
        for (int c = 0; c < 3000 && !hit; c++) begin
            @(negedge clk);
            hit = (go_dat.size() == 7);
        end
        chk("mid_rst/reached_e6", hit, 1'b1);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("mid_rst");
        n = go_dat.size();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (150) @(negedge clk);
        chk("mid_rst/no_go", go_dat.size(), n);
        set_decisions(0, 50, 1'b0, 0);
        run_case("post_rst");

        // Randomised rounds with spurious starts while busy.
        spur_en = 1'b1;
        for (int r = 0; r < 4; r++) begin
            dec_lat.delete();
            dec_nack.delete();
            for (int k = 0; k < 44; k++) begin
                int sel, lat;
                bit nk;
                sel = $urandom_range(0, 9);
                nk  = 1'b0;
                case (sel)
                    0:       begin lat = $urandom_range(1, 60); nk = 1'b1; end
                    1:       lat = 0;
                    2:       lat = TMO;
                    3:       lat = TMO + $urandom_range(1, 10);
                    default: lat = $urandom_range(1, 60);
                endcase
                dec_lat.push_back(lat);
                dec_nack.push_back(nk);
            end
            run_case($sformatf("rand%0d", r));
        end
        spur_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, want finish within 60000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
